// File: rtl/memory_responder_if.sv
// Core-to-memory bus: fetch/data requests, preload port and registered responses.
interface memory_responder_if;
  logic [31:0] instr_addr;
  logic [31:0] data_addr;
  logic        should_read_mem;
  logic        should_write_mem;
  logic [31:0] mem_write_data;
  logic        init_we;
  logic [31:0] init_addr;
  logic [31:0] init_data;
  logic [31:0] instr;
  logic [31:0] mem_read_data;
  logic        busy;
  logic        fault;

  // Core / bench side.
  modport master (
    output instr_addr, data_addr, should_read_mem, should_write_mem, mem_write_data,
    output init_we, init_addr, init_data,
    input  instr, mem_read_data, busy, fault
  );

  // Responder side.
  modport slave (
    input  instr_addr, data_addr, should_read_mem, should_write_mem, mem_write_data,
    input  init_we, init_addr, init_data,
    output instr, mem_read_data, busy, fault
  );
endinterface

// File: rtl/memory_responder.sv
// Multi-cycle single-ported memory model serving one instruction fetch and at most one
// data access per instruction, with a one-cycle busy=0 commit window for the core.
module memory_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  memory_responder_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAST  = 4'(MEM_LATENCY - 1);
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef enum logic [1:0] {StFetch, StDecide, StData, StCommit} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] fetch_addr_q, fetch_addr;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [31:0] daddr_q, daddr_d, wdata_q, wdata_d;
  logic        mem_we;
  logic        last;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= LIMIT);
  endfunction

  // The core presents the new PC in the first FETCH cycle; hold it for later cycles.
  assign fetch_addr = (cnt_q == 4'd0) ? bus.instr_addr : fetch_addr_q;
  assign last       = (cnt_q == LAST);

  // Next-state, counter and response computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    instr_d       = instr_q;
    rdata_d       = rdata_q;
    fault_d       = 1'b0;
    fetch_fault_d = fetch_fault_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    daddr_d       = daddr_q;
    wdata_d       = wdata_q;
    mem_we        = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (last) begin
          cnt_d         = 4'd0;
          fetch_fault_d = bad_addr(fetch_addr);
          instr_d       = bad_addr(fetch_addr) ? NOP : mem[fetch_addr[AW+1:2]];
          state_d       = StDecide;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDecide: begin
        rd_d    = bus.should_read_mem;
        wr_d    = bus.should_write_mem;
        daddr_d = bus.data_addr;
        wdata_d = bus.mem_write_data;
        if (!fetch_fault_q && (bus.should_read_mem || bus.should_write_mem)) begin
          state_d = StData;
        end else begin
          state_d = StCommit;
          fault_d = fetch_fault_q;
        end
      end
      StData: begin
        if (last) begin
          cnt_d   = 4'd0;
          state_d = StCommit;
          // Conflicting strobes still spend the DATA latency but touch nothing.
          if ((rd_q && wr_q) || bad_addr(daddr_q)) begin
            rdata_d = 32'h0;
            fault_d = 1'b1;
          end else if (rd_q) begin
            rdata_d = mem[daddr_q[AW+1:2]];
          end else begin
            mem_we = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCommit: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
    busy_d = (state_d != StCommit);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetch;
      cnt_q         <= 4'd0;
      fetch_addr_q  <= 32'h0;
      instr_q       <= NOP;
      rdata_q       <= 32'h0;
      busy_q        <= 1'b1;
      fault_q       <= 1'b0;
      fetch_fault_q <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      daddr_q       <= 32'h0;
      wdata_q       <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_addr_q  <= fetch_addr;
      instr_q       <= instr_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      fetch_fault_q <= fetch_fault_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      daddr_q       <= daddr_d;
      wdata_q       <= wdata_d;
    end
  end

  // Array writes: preload only under reset, stores only out of reset; never cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (bus.init_we && !bad_addr(bus.init_addr)) begin
        mem[bus.init_addr[AW+1:2]] <= bus.init_data;
      end
    end else if (mem_we) begin
      mem[daddr_q[AW+1:2]] <= wdata_q;
    end
  end

  assign bus.instr         = instr_q;
  assign bus.mem_read_data = rdata_q;
  assign bus.busy          = busy_q;
  assign bus.fault         = fault_q;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed scenarios plus randomized instructions, checked every
// cycle against a per-instruction timing/content model and a shadow copy of the array.
module tb_memory_responder;
  localparam int DEPTH = 1024;
  localparam int ML    = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic reset;
  memory_responder_if bus ();

  memory_responder #(.DEPTH_WORDS(DEPTH), .MEM_LATENCY(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Expected outputs for the current cycle, set 1ns after each rising edge.
  logic        exp_valid = 1'b0;
  logic        exp_busy, exp_fault;
  logic [31:0] exp_instr, exp_mrd;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] prev_instr, prev_mrd;

  // Values the DUT showed during the last instruction, for literal checks.
  int          busy_cnt;
  logic [31:0] commit_instr, commit_mrd;
  logic        commit_fault;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      vectors++;
      if (bus.busy !== exp_busy || bus.fault !== exp_fault ||
          bus.instr !== exp_instr || bus.mem_read_data !== exp_mrd) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got busy=%b fault=%b instr=%h mrd=%h, want busy=%b fault=%b instr=%h mrd=%h",
                 $time, bus.busy, bus.fault, bus.instr, bus.mem_read_data,
                 exp_busy, exp_fault, exp_instr, exp_mrd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
  endfunction

  task automatic set_reset_exp();
    exp_busy  = 1'b1;
    exp_fault = 1'b0;
    exp_instr = NOP;
    exp_mrd   = 32'h0;
  endtask

  // Runs one instruction from its first FETCH cycle; abort_k >= 0 asserts reset in that cycle.
  task automatic run_instr(input logic [31:0] ia, input logic rd, input logic wr,
                           input logic [31:0] da, input logic [31:0] wd, input int abort_k);
    logic        fbad, req, dfault, fexp;
    logic [31:0] new_instr, new_mrd;
    int          n_busy;
    bus.instr_addr       = ia;
    bus.should_read_mem  = rd;
    bus.should_write_mem = wr;
    bus.data_addr        = da;
    bus.mem_write_data   = wd;
    fbad      = is_bad(ia);
    new_instr = fbad ? NOP : model_mem[ia[11:2]];
    req       = !fbad && (rd || wr);
    dfault    = req && ((rd && wr) || is_bad(da));
    fexp      = fbad || dfault;
    n_busy    = ML + 1 + (req ? ML : 0);
    if (!req) new_mrd = prev_mrd;
    else if (dfault) new_mrd = 32'h0;
    else if (rd) new_mrd = model_mem[da[11:2]];
    else new_mrd = prev_mrd;
    busy_cnt = 0;
    for (int k = 0; k <= n_busy; k++) begin
      exp_busy  = (k < n_busy);
      exp_fault = (k == n_busy) && fexp;
      exp_instr = (k < ML) ? prev_instr : new_instr;
      exp_mrd   = (k < n_busy) ? prev_mrd : new_mrd;
      exp_valid = 1'b1;
      if (bus.busy === 1'b1) busy_cnt++;
      if (k == n_busy) begin
        commit_instr = bus.instr;
        commit_mrd   = bus.mem_read_data;
        commit_fault = bus.fault;
      end
      if (k == abort_k) begin
        reset = 1'b1;
        @(posedge clk); #1;
        set_reset_exp();
        @(posedge clk); #1;
        reset      = 1'b0;
        prev_instr = NOP;
        prev_mrd   = 32'h0;
        return;
      end
      @(posedge clk); #1;
    end
    if (req && wr && !dfault) model_mem[da[11:2]] = wd;
    prev_instr = new_instr;
    prev_mrd   = new_mrd;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bus.init_we   = 1'b1;
    bus.init_addr = a;
    bus.init_data = d;
    if (!is_bad(a)) model_mem[a[11:2]] = d;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ia, da, wd;
    logic        rd, wr;
    reset                = 1'b1;
    bus.instr_addr       = 32'h0;
    bus.data_addr        = 32'h0;
    bus.should_read_mem  = 1'b0;
    bus.should_write_mem = 1'b0;
    bus.mem_write_data   = 32'h0;
    bus.init_we          = 1'b0;
    bus.init_addr        = 32'h0;
    bus.init_data        = 32'h0;
    @(posedge clk); #1;
    set_reset_exp();
    exp_valid = 1'b1;

    for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);
    preload(32'h0, 32'h00500093);
    preload(32'h80, 32'h11111111);
    preload(32'h1008, 32'hBAD0BAD0);  // out of range, would alias word 2
    preload(32'h000D, 32'hBAD1BAD1);  // misaligned, would alias word 3
    bus.init_we = 1'b0;
    reset       = 1'b0;
    prev_instr  = NOP;
    prev_mrd    = 32'h0;

    // Plain fetch of the preloaded word 0.
    run_instr(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1);
    chk("nomem_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("nomem_instr", commit_instr, 32'h00500093);
    chk("nomem_fault", {31'b0, commit_fault}, 32'd0);
    // Store then load back.
    run_instr(32'h4, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, -1);
    chk("store_busy_cycles", 32'(busy_cnt), 32'd5);
    run_instr(32'h8, 1'b1, 1'b0, 32'h40, 32'h0, -1);
    chk("load_after_store", commit_mrd, 32'hDEADBEEF);
    // Misaligned load.
    run_instr(32'hC, 1'b1, 1'b0, 32'h41, 32'h0, -1);
    chk("misaligned_load_data", commit_mrd, 32'h0);
    chk("misaligned_load_fault", {31'b0, commit_fault}, 32'd1);
    // Out-of-range fetch skips the data phase.
    run_instr(32'h1000, 1'b1, 1'b0, 32'h40, 32'h0, -1);
    chk("bad_fetch_instr", commit_instr, NOP);
    chk("bad_fetch_fault", {31'b0, commit_fault}, 32'd1);
    chk("bad_fetch_busy_cycles", 32'(busy_cnt), 32'd3);
    // Reset during the first DATA cycle of a store to 0x80.
    run_instr(32'h10, 1'b0, 1'b1, 32'h80, 32'h22222222, ML + 1);
    run_instr(32'h14, 1'b1, 1'b0, 32'h80, 32'h0, -1);
    chk("reset_aborts_store", commit_mrd, 32'h11111111);
    // Conflicting read and write strobes.
    run_instr(32'h18, 1'b1, 1'b1, 32'h40, 32'h55555555, -1);
    chk("both_strobes_data", commit_mrd, 32'h0);
    chk("both_strobes_fault", {31'b0, commit_fault}, 32'd1);
    chk("both_strobes_busy_cycles", 32'(busy_cnt), 32'd5);
    run_instr(32'h1C, 1'b1, 1'b0, 32'h40, 32'h0, -1);
    chk("both_strobes_no_write", commit_mrd, 32'hDEADBEEF);

    // Randomized instructions; init_we toggles freely since it must be ignored out of reset.
    for (int n = 0; n < 300; n++) begin
      ia = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 9) == 0) ia = ($urandom_range(0, 1) != 0) ? (ia | 32'h2) : (ia + 32'h1000);
      da = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) da = ($urandom_range(0, 1) != 0) ? (da | 32'h1) : (da + 32'h4000);
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      bus.init_we   = ($urandom_range(0, 1) != 0);
      bus.init_addr = 32'($urandom_range(0, 255)) << 2;
      bus.init_data = $urandom;
      run_instr(ia, rd, wr, da, wd, -1);
    end

    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
